// File: rtl/io_loop_tester_if.sv
// Wishbone slave bus bundle for io_loop_tester; the master side drives strobe/cycle/address/data,
// the slave side returns ack and read data.
interface io_loop_tester_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_adr_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/io_loop_tester.sv
// Serial pad loopback tester: sends TXD as a UART-like frame on tx_o and compares what comes back on rx_i.
// Optional done interrupt enabled by defining IO_LOOP_TESTER_IRQ_EN.
//
// state   | meaning
// IDLE    | line idle high, waiting for START
// START   | start bit (0) for one bit period
// DATA    | TXD bits LSB-first, LEN+1 bit periods
// STOP    | stop bit (1) for one bit period
// CHECK   | one cycle: compare RXD/stop sample, set DONE
module io_loop_tester #(
    parameter logic [31:0] BASE_ADR = 32'h3000_0000,
    parameter int unsigned MIN_DIV  = 4
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_n,
    io_loop_tester_if.slave wb,
    output logic            tx_o,
    output logic            tx_oeb,
    input  logic            rx_i,
    output logic            irq_o
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_CHECK = 3'd4;

    localparam logic [7:0] A_CTRL = 8'h00;
    localparam logic [7:0] A_TXD  = 8'h04;
    localparam logic [7:0] A_DIV  = 8'h08;
    localparam logic [7:0] A_RXD  = 8'h0C;
    localparam logic [7:0] A_STAT = 8'h10;

    localparam logic [15:0] MIN_DIV_W = 16'(MIN_DIV);

    logic [2:0]  state, state_nxt;
    logic [15:0] cnt, cnt_nxt, div_eff;
    logic [4:0]  idx, idx_nxt;
    logic [31:0] txd, rxd, rdata, len_mask;
    logic [15:0] div;
    logic [4:0]  len;
    logic        done, mismatch, stop_bit, irq_en;
    logic        rx_s1, rx_s2;
    logic        hit, wr, rd, busy, start_req, bit_end, sample, tx_nxt, stat_wr;
    logic [7:0]  off;

    assign off       = wb.wbs_adr_i[7:0];
    assign hit       = wb.wbs_stb_i & wb.wbs_cyc_i & ~wb.wbs_ack_o
                     & (wb.wbs_adr_i[31:8] == BASE_ADR[31:8]);
    assign wr        = hit & wb.wbs_we_i;
    assign rd        = hit & ~wb.wbs_we_i;
    assign busy      = (state != S_IDLE);
    assign start_req = wr && (off == A_CTRL) && wb.wbs_sel_i[0] && wb.wbs_dat_i[0] && !busy;
    assign stat_wr   = wr && (off == A_STAT) && wb.wbs_sel_i[0];
    assign div_eff   = (div < MIN_DIV_W) ? MIN_DIV_W : div;
    assign bit_end   = (cnt == div_eff - 16'd1);
    assign sample    = (cnt == (div_eff >> 1));
    assign len_mask  = 32'hFFFF_FFFF >> (5'd31 - len);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        case (state)
            S_IDLE: if (start_req) begin
                state_nxt = S_START;
                cnt_nxt   = '0;
            end
            S_START: if (bit_end) begin
                state_nxt = S_DATA;
                cnt_nxt   = '0;
                idx_nxt   = '0;
            end else cnt_nxt = cnt + 16'd1;
            S_DATA: if (bit_end) begin
                cnt_nxt = '0;
                if (idx == len) state_nxt = S_STOP;
                else            idx_nxt   = idx + 5'd1;
            end else cnt_nxt = cnt + 16'd1;
            S_STOP: if (bit_end) begin
                state_nxt = S_CHECK;
                cnt_nxt   = '0;
            end else cnt_nxt = cnt + 16'd1;
            S_CHECK: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // tx_o is registered from the next state so the pin changes on the same edge as the FSM
    always_comb begin
        case (state_nxt)
            S_START: tx_nxt = 1'b0;
            S_DATA:  tx_nxt = txd[idx_nxt];
            default: tx_nxt = 1'b1;
        endcase
    end

    always_comb begin
        case (off)
            A_CTRL:  rdata = {19'b0, len, 8'b0};
            A_TXD:   rdata = txd;
            A_DIV:   rdata = {16'b0, div};
            A_RXD:   rdata = rxd;
            A_STAT:  rdata = {28'b0, irq_en, mismatch, done, busy};
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state         <= S_IDLE;
            cnt           <= '0;
            idx           <= '0;
            txd           <= '0;
            rxd           <= '0;
            div           <= 16'd16;
            len           <= 5'd31;
            done          <= 1'b0;
            mismatch      <= 1'b0;
            stop_bit      <= 1'b1;
            tx_o          <= 1'b1;
            tx_oeb        <= 1'b1;
            rx_s1         <= 1'b1;
            rx_s2         <= 1'b1;
            wb.wbs_ack_o  <= 1'b0;
            wb.wbs_dat_o  <= '0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            idx          <= idx_nxt;
            tx_o         <= tx_nxt;
            tx_oeb       <= 1'b0;
            rx_s1        <= rx_i;
            rx_s2        <= rx_s1;
            wb.wbs_ack_o <= hit;
            wb.wbs_dat_o <= rd ? rdata : '0;

            if (wr && !busy) begin
                case (off)
                    A_TXD:
                        for (int b = 0; b < 4; b++)
                            if (wb.wbs_sel_i[b]) txd[8*b +: 8] <= wb.wbs_dat_i[8*b +: 8];
                    A_DIV: begin
                        if (wb.wbs_sel_i[0]) div[7:0]  <= wb.wbs_dat_i[7:0];
                        if (wb.wbs_sel_i[1]) div[15:8] <= wb.wbs_dat_i[15:8];
                    end
                    A_CTRL: if (wb.wbs_sel_i[1]) len <= wb.wbs_dat_i[12:8];
                    default: ;
                endcase
            end

            if (stat_wr) begin
                if (wb.wbs_dat_i[1]) done     <= 1'b0;
                if (wb.wbs_dat_i[2]) mismatch <= 1'b0;
            end

            if (start_req) rxd <= '0;

            // status sets come after the W1C clears so a coincident set wins
            if (sample) begin
                case (state)
                    S_START: if (rx_s2) mismatch <= 1'b1;
                    S_DATA:  rxd[idx] <= rx_s2;
                    S_STOP:  stop_bit <= rx_s2;
                    default: ;
                endcase
            end

            if (state == S_CHECK) begin
                done <= 1'b1;
                if ((rxd != (txd & len_mask)) || !stop_bit) mismatch <= 1'b1;
            end
        end
    end

`ifdef IO_LOOP_TESTER_IRQ_EN
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            irq_en <= 1'b0;
            irq_o  <= 1'b0;
        end else begin
            if (stat_wr) irq_en <= wb.wbs_dat_i[3];
            irq_o <= done & irq_en;
        end
    end
`else
    assign irq_en = 1'b0;
    assign irq_o  = 1'b0;
`endif
endmodule
